nes_test_pattern_gen: RTL and testbench

//  Parametrised NES-palette test-pattern source driving the PPU-side write port of vga_fb.

---
 rtl/nes_test_pattern_gen_if.sv | 26 ++
 rtl/nes_test_pattern_gen.sv | 160 ++++++++++++++++
 tb/tb_nes_test_pattern_gen.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_test_pattern_gen_if.sv
// Pixel-stream and control bundle between the NES test-pattern source and the vga_fb PPU write port.
// master = pattern generator, slave = frame buffer / controlling logic.
interface nes_test_pattern_gen_if;
    logic [1:0] mode;
    logic [5:0] solid_col;
    logic       cont;
    logic       start;
    logic       fb_ready;
    logic       ppu_we;
    logic [7:0] ppu_ptr_x;
    logic [7:0] ppu_ptr_y;
    logic [5:0] ppu_DI;
    logic       busy;
    logic       frame_done;
    logic [7:0] grid_center;

    modport master (
        input  mode, solid_col, cont, start, fb_ready,
        output ppu_we, ppu_ptr_x, ppu_ptr_y, ppu_DI, busy, frame_done, grid_center
    );

    modport slave (
        output mode, solid_col, cont, start, fb_ready,
        input  ppu_we, ppu_ptr_x, ppu_ptr_y, ppu_DI, busy, frame_done, grid_center
    );
endinterface

// File: rtl/nes_test_pattern_gen.sv
// NES-palette test-pattern source: streams one raster frame of 6-bit palette indices over a valid/ready port.
// Optional build macro PAT_BORDER_EN forces the outermost pixel ring to 'h30 in every mode.
module nes_test_pattern_gen #(
    parameter int H_PIX    = 256,
    parameter int V_PIX    = 240,
    parameter int SETTLE   = 256,
    parameter int MOVE_DIV = 1200000
) (
    input  logic                  ppu_clk,
    input  logic                  rst,
    nes_test_pattern_gen_if.master pg
);

    localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int              MW          = $clog2(MOVE_DIV);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [MW-1:0]   MOVE_LAST   = MW'(MOVE_DIV - 1);
    localparam logic [7:0]      X_LAST      = 8'(H_PIX - 1);
    localparam logic [7:0]      Y_LAST      = 8'(V_PIX - 1);
    localparam logic [31:0]     H_PIX_W     = 32'(H_PIX);
    localparam logic [5:0]      BAR_COL [8] = '{6'h30, 6'h28, 6'h2C, 6'h2A,
                                                6'h24, 6'h16, 6'h12, 6'h0F};

    typedef enum logic [1:0] {S_SETTLE, S_IDLE, S_DRAW, S_DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] settle_cnt;
    logic [MW-1:0] move_cnt;
    logic [7:0]    grid_center;

    logic [1:0]    mode_f;
    logic [5:0]    sc_f;
    logic [7:0]    gc_f;

    logic [7:0]    x_p0;
    logic [7:0]    y_p0;
    logic [5:0]    di_p0;
    logic [7:0]    x_nxt;
    logic [7:0]    y_nxt;

    logic          last_px;
    logic          xfer;
    logic          frame_start;

    function automatic logic [5:0] pat_colour(
        input logic [1:0] md,
        input logic [5:0] sc,
        input logic [7:0] gc,
        input logic [7:0] px,
        input logic [7:0] py
    );
        logic [2:0] bar_idx;
        logic [5:0] c;
        bar_idx = 3'((32'(px) * 32'd8) / H_PIX_W);
        unique case (md)
            2'd0: begin
                if (px < gc) c = (py < gc) ? 6'h27 : 6'h14;
                else         c = (py < gc) ? 6'h01 : 6'h2b;
            end
            2'd1:    c = BAR_COL[bar_idx];
            2'd2:    c = (px[3] ^ py[3]) ? 6'h30 : 6'h0F;
            default: c = sc;
        endcase
`ifdef PAT_BORDER_EN
        if (px == 8'd0 || px == X_LAST || py == 8'd0 || py == Y_LAST) c = 6'h30;
`endif
        return c;
    endfunction

    assign last_px     = (x_p0 == X_LAST) && (y_p0 == Y_LAST);
    assign xfer        = (state == S_DRAW) && pg.fb_ready;
    assign frame_start = (state_nxt == S_DRAW) && (state != S_DRAW);

    always_ff @(posedge ppu_clk) begin
        if (!rst) state <= S_SETTLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = S_IDLE;
            S_IDLE:   if (pg.start || pg.cont) state_nxt = S_DRAW;
            S_DRAW:   if (xfer && last_px) state_nxt = S_DONE;
            S_DONE:   state_nxt = pg.cont ? S_DRAW : S_IDLE;
            default:  state_nxt = S_SETTLE;
        endcase
    end

    // Valid is simply "in DRAW": the pixel registers always hold a pending pixel there.
    always_comb begin
        pg.ppu_we     = (state == S_DRAW);
        pg.busy       = (state == S_DRAW);
        pg.frame_done = (state == S_DONE);
    end

    always_ff @(posedge ppu_clk) begin
        if (!rst) begin
            settle_cnt <= '0;
        end else if (state == S_SETTLE && settle_cnt != SETTLE_LAST) begin
            settle_cnt <= settle_cnt + SW'(1);
        end
    end

    always_ff @(posedge ppu_clk) begin
        if (!rst) begin
            move_cnt    <= '0;
            grid_center <= 8'd0;
        end else if (state != S_SETTLE) begin
            if (move_cnt == MOVE_LAST) begin
                move_cnt    <= '0;
                grid_center <= grid_center + 8'd1;
            end else begin
                move_cnt <= move_cnt + MW'(1);
            end
        end
    end

    // Frame-constant pattern settings; only meaningful while a frame is drawn.
    always_ff @(posedge ppu_clk) begin
        if (frame_start) begin
            mode_f <= pg.mode;
            sc_f   <= pg.solid_col;
            gc_f   <= grid_center;
        end
    end

    always_comb begin
        x_nxt = x_p0 + 8'd1;
        y_nxt = y_p0;
        if (x_p0 == X_LAST) begin
            x_nxt = 8'd0;
            y_nxt = y_p0 + 8'd1;
        end
    end

    // Stage p0: pointers and colour update together so they never disagree.
    always_ff @(posedge ppu_clk) begin
        if (!rst) begin
            x_p0  <= 8'd0;
            y_p0  <= 8'd0;
            di_p0 <= 6'd0;
        end else if (frame_start) begin
            x_p0  <= 8'd0;
            y_p0  <= 8'd0;
            di_p0 <= pat_colour(pg.mode, pg.solid_col, grid_center, 8'd0, 8'd0);
        end else if (xfer && !last_px) begin
            x_p0  <= x_nxt;
            y_p0  <= y_nxt;
            di_p0 <= pat_colour(mode_f, sc_f, gc_f, x_nxt, y_nxt);
        end
    end

    assign pg.ppu_ptr_x   = x_p0;
    assign pg.ppu_ptr_y   = y_p0;
    assign pg.ppu_DI      = di_p0;
    assign pg.grid_center = grid_center;

endmodule

// File: tb/tb_nes_test_pattern_gen.sv
// Scoreboard bench for nes_test_pattern_gen on a reduced raster; honours PAT_BORDER_EN in its colour model.
`timescale 1ns/1ps
module tb_nes_test_pattern_gen;

    localparam int TB_H      = 124;
    localparam int TB_V      = 122;
    localparam int TB_SETTLE = 256;
    localparam int TB_MD     = 4;

    typedef struct packed {
        logic [1:0] mode;
        logic [5:0] sc;
        logic [7:0] gc;
    } frame_t;

    logic ppu_clk;
    logic rst;
    nes_test_pattern_gen_if ifc();

    nes_test_pattern_gen #(
        .H_PIX(TB_H), .V_PIX(TB_V), .SETTLE(TB_SETTLE), .MOVE_DIV(TB_MD)
    ) dut (
        .ppu_clk(ppu_clk),
        .rst    (rst),
        .pg     (ifc)
    );

    initial ppu_clk = 1'b0;
    always #5 ppu_clk = ~ppu_clk;

    int     n_cmp = 0;
    int     n_err = 0;
    int     fd_count = 0;
    int     ecnt;
    logic   mon_en = 1'b0;
    logic   rnd_ready = 1'b0;
    frame_t sb_q[$];
    logic [5:0] bar_tab [8] = '{6'h30, 6'h28, 6'h2C, 6'h2A, 6'h24, 6'h16, 6'h12, 6'h0F};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Edges with rst released since the last reset; grid_center follows from it alone.
    always @(posedge ppu_clk) begin
        if (!rst) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    function automatic logic [7:0] gc_model();
        if (ecnt < TB_SETTLE) return 8'd0;
        return 8'(((ecnt - TB_SETTLE) / TB_MD) % 256);
    endfunction

    function automatic logic [5:0] exp_pix(input frame_t f, input int x, input int y);
        int gc;
        gc = int'(f.gc);
`ifdef PAT_BORDER_EN
        if (x == 0 || x == TB_H - 1 || y == 0 || y == TB_V - 1) return 6'h30;
`endif
        case (f.mode)
            2'd0: begin
                if (y < gc) return (x < gc) ? 6'h27 : 6'h01;
                else        return (x < gc) ? 6'h14 : 6'h2b;
            end
            2'd1:    return bar_tab[(x * 8) / TB_H];
            2'd2:    return ((((x / 8) + (y / 8)) % 2) == 1) ? 6'h30 : 6'h0F;
            default: return f.sc;
        endcase
    endfunction

    initial begin
        ifc.fb_ready = 1'b1;
        forever begin
            @(posedge ppu_clk);
            #1;
            ifc.fb_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: pops a frame descriptor on the first valid pixel and walks it in raster order.
    initial begin
        frame_t      cur;
        logic        cur_vld = 1'b0;
        logic        fd_due = 1'b0;
        logic        hold_vld = 1'b0;
        logic [31:0] hold_val = '0;
        int          ex = 0;
        int          ey = 0;
        forever begin
            @(negedge ppu_clk);
            if (!mon_en) begin
                cur_vld  = 1'b0;
                fd_due   = 1'b0;
                hold_vld = 1'b0;
            end else begin
                check_val("frame_done", 32'(ifc.frame_done), 32'(fd_due));
                fd_due = 1'b0;
                if (ifc.frame_done) begin
                    fd_count++;
                    if (ifc.cont) sb_q.push_back('{ifc.mode, ifc.solid_col, gc_model()});
                end
                if (hold_vld) begin
                    check_val("hold", 32'({ifc.ppu_we, ifc.ppu_ptr_x, ifc.ppu_ptr_y, ifc.ppu_DI}), hold_val);
                    hold_vld = 1'b0;
                end
                if (ifc.ppu_we && !cur_vld) begin
                    if (sb_q.size() == 0) begin
                        check_val("we_unexpected", 32'(ifc.ppu_we), 32'd0);
                    end else begin
                        cur     = sb_q.pop_front();
                        cur_vld = 1'b1;
                        ex      = 0;
                        ey      = 0;
                    end
                end
                if (ifc.ppu_we && cur_vld) begin
                    if (ifc.fb_ready) begin
                        check_val("pixel", 32'({ifc.ppu_ptr_x, ifc.ppu_ptr_y, ifc.ppu_DI}),
                                  32'({8'(ex), 8'(ey), exp_pix(cur, ex, ey)}));
                        if (ex == TB_H - 1) begin
                            ex = 0;
                            if (ey == TB_V - 1) begin
                                cur_vld = 1'b0;
                                fd_due  = 1'b1;
                            end else begin
                                ey++;
                            end
                        end else begin
                            ex++;
                        end
                    end else begin
                        hold_vld = 1'b1;
                        hold_val = 32'({1'b1, ifc.ppu_ptr_x, ifc.ppu_ptr_y, ifc.ppu_DI});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ppu_clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_ctrl"}, 32'({ifc.ppu_we, ifc.busy, ifc.frame_done, ifc.grid_center}), 32'd0);
        check_val({tag, "_pix"},  32'({ifc.ppu_ptr_x, ifc.ppu_ptr_y, ifc.ppu_DI}), 32'd0);
    endtask

    task automatic settle_check(input int start_at);
        for (int c = 0; c < TB_SETTLE; c++) begin
            tick();
            ifc.start = (c == start_at);
            @(negedge ppu_clk);
            check_val("settle_busy", 32'(ifc.busy), 32'd0);
        end
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] md, input logic [5:0] sc);
        ifc.mode      = md;
        ifc.solid_col = sc;
        ifc.start     = 1'b1;
        sb_q.push_back('{md, sc, gc_model()});
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int budget);
        int n = 0;
        while (fd_count < target && n < budget) begin
            tick();
            n++;
        end
        check_val("fd_count", 32'(fd_count), 32'(target));
    endtask

    initial begin
        int n;
        rst = 1'b0;
        ifc.mode = 2'd0;
        ifc.solid_col = 6'd0;
        ifc.cont = 1'b0;
        ifc.start = 1'b0;

        repeat (5) @(posedge ppu_clk);
        @(negedge ppu_clk);
        check_reset_outs("rst");
        tick();
        rst = 1'b1;
        mon_en = 1'b1;
        settle_check(99);

        // Solid frame, always ready.
        start_frame(2'd3, 6'h21);
        @(negedge ppu_clk);
        check_val("first_we", 32'({ifc.ppu_we, ifc.ppu_ptr_x, ifc.ppu_ptr_y}), 32'({1'b1, 16'd0}));
        wait_fd(1, TB_H * TB_V + 100);
        @(negedge ppu_clk);
        check_val("idle_busy_a", 32'(ifc.busy), 32'd0);

        // Quadrant frame at grid_center 120, start together with cont.
        n = 0;
        while (gc_model() != 8'd120 && n < 3000) begin
            tick();
            n++;
        end
        check_val("gc_at_start", 32'(ifc.grid_center), 32'd120);
        ifc.cont = 1'b1;
        start_frame(2'd0, 6'h00);
        for (int i = 0; i < 64; i++) begin
            @(negedge ppu_clk);
            check_val("gc_track", 32'(ifc.grid_center), 32'(gc_model()));
        end
        wait_fd(2, TB_H * TB_V + 100);

        // Continuation frame under random back-pressure; cont dropped so it ends in IDLE.
        ifc.cont = 1'b0;
        rnd_ready = 1'b1;
        wait_fd(3, 3 * TB_H * TB_V);
        @(negedge ppu_clk);
        check_val("idle_busy_c", 32'(ifc.busy), 32'd0);

        // Checkerboard under back-pressure, abandoned by reset at (37,10).
        start_frame(2'd2, 6'h00);
        n = 0;
        do begin
            @(negedge ppu_clk);
            n++;
        end while (!(ifc.ppu_we && ifc.ppu_ptr_x == 8'd37 && ifc.ppu_ptr_y == 8'd10) && n < 20000);
        check_val("reach_37_10", 32'({ifc.ppu_ptr_x, ifc.ppu_ptr_y}), 32'({8'd37, 8'd10}));
        tick();
        rst = 1'b0;
        mon_en = 1'b0;
        rnd_ready = 1'b0;
        sb_q.delete();
        repeat (3) tick();
        @(negedge ppu_clk);
        check_reset_outs("rst_mid");
        tick();
        rst = 1'b1;
        mon_en = 1'b1;
        settle_check(10);
        check_val("no_fd_abort", 32'(fd_count), 32'd3);

        // Colour bars, always ready.
        start_frame(2'd1, 6'h00);
        wait_fd(4, TB_H * TB_V + 100);
        @(negedge ppu_clk);
        check_val("idle_busy_e", 32'(ifc.busy), 32'd0);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
